// File: rtl/common_pkg.sv
// Shared datapath types for the MIPS pipeline.
package common;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/fetch_pkg.sv
// Types and constants shared by the instruction-fetch stage and its next-PC mux.
package fetch_pkg;
    typedef common::word_t word_t;

    localparam word_t RESET_PC_DEFAULT = 32'hbfc0_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t pc;
        word_t pcplus4;
        word_t raw_instr;
        logic  exception_instr;
    } fetch_data_t;

    function automatic word_t pcPlus4(input word_t pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/fetch_stage_pc_select.sv
// Combinational next-PC mux: exception redirect, then pending branch/jump target, then PC+4.
module pc_select
    import fetch_pkg::*;
(
    input  word_t i_pc,
    input  logic  i_exc_valid,
    input  word_t i_exc_pc,
    input  logic  i_pend_valid,
    input  word_t i_pend_pc,
    input  logic  i_d_redirect,
    input  logic  i_is_jr,
    input  logic  i_is_jump,
    input  word_t i_pcbranch,
    input  word_t i_pcjump,
    input  word_t i_pcjr,
    output logic  o_pend_valid,
    output word_t o_pend_pc,
    output word_t o_next_pc
);
    word_t w_target;

    // A redirect arriving this cycle replaces whatever target is already pending.
    always_comb begin
        w_target     = i_is_jr ? i_pcjr : (i_is_jump ? i_pcjump : i_pcbranch);
        o_pend_valid = i_d_redirect | i_pend_valid;
        o_pend_pc    = i_d_redirect ? w_target : i_pend_pc;
        if (i_exc_valid) begin
            o_next_pc = i_exc_pc;
        end else if (o_pend_valid) begin
            o_next_pc = o_pend_pc;
        end else begin
            o_next_pc = pcPlus4(i_pc);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives the instruction bus, holds the F->D word.
// Optional FETCH_ADDR_ERR_EN: misaligned PC raises AdEL in exception_instr instead of fetching.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT,
    parameter int    EXC_BITS = 1
) (
    input  logic                clk,
    input  logic                resetn,
    output logic                o_ireq_valid,
    output word_t               o_ireq_addr,
    input  logic                i_ireq_addr_ok,
    input  logic                i_iresp_data_ok,
    input  word_t               i_iresp_data,
    input  logic                i_branch_taken,
    input  logic                i_is_jump,
    input  logic                i_is_jr,
    input  word_t               i_pcbranch,
    input  word_t               i_pcjump,
    input  word_t               i_pcjr,
    input  logic                i_exc_valid,
    input  word_t               i_exc_pc,
    input  logic                i_stallF,
    input  logic                i_flushD,
    output logic                o_dataF_valid,
    output word_t               o_dataF_pc,
    output word_t               o_dataF_pcplus4,
    output word_t               o_dataF_raw_instr,
    output logic [EXC_BITS-1:0] o_dataF_exception_instr,
    output logic                o_fetch_busy
);
    fetch_state_t r_state, w_stateNext;
    word_t        r_pc, r_pendPc, w_pendPc, w_nextPc;
    logic         r_pendValid, w_pendValid;
    logic [1:0]   r_discardCnt;
    fetch_data_t  r_data;
    logic         r_dataValid;
    logic         w_dRedirect, w_stale, w_addrErr;
    logic         w_latch, w_errLatch, w_advance, w_discardInc, w_ireqValid;

    assign w_dRedirect = (i_branch_taken | i_is_jump | i_is_jr) & ~i_stallF;
    assign w_stale     = i_iresp_data_ok & (r_discardCnt != 2'd0);

`ifdef FETCH_ADDR_ERR_EN
    assign w_addrErr   = (r_pc[1:0] != 2'b00);
    assign o_ireq_addr = r_pc;
`else
    assign w_addrErr   = 1'b0;
    assign o_ireq_addr = {r_pc[31:2], 2'b00};
`endif

    pc_select u_pcSelect (
        .i_pc         (r_pc),
        .i_exc_valid  (i_exc_valid),
        .i_exc_pc     (i_exc_pc),
        .i_pend_valid (r_pendValid),
        .i_pend_pc    (r_pendPc),
        .i_d_redirect (w_dRedirect),
        .i_is_jr      (i_is_jr),
        .i_is_jump    (i_is_jump),
        .i_pcbranch   (i_pcbranch),
        .i_pcjump     (i_pcjump),
        .i_pcjr       (i_pcjr),
        .o_pend_valid (w_pendValid),
        .o_pend_pc    (w_pendPc),
        .o_next_pc    (w_nextPc)
    );

    // A request accepted alongside an exception, or abandoned in WAIT, leaves a response to drop.
    always_comb begin
        w_stateNext  = r_state;
        w_latch      = 1'b0;
        w_errLatch   = 1'b0;
        w_advance    = 1'b0;
        w_discardInc = 1'b0;
        w_ireqValid  = 1'b0;
        case (r_state)
            REQ: begin
                w_ireqValid = ~w_addrErr;
                if (i_exc_valid) begin
                    w_discardInc = i_ireq_addr_ok & ~w_addrErr;
                end else if (w_addrErr) begin
                    w_errLatch  = 1'b1;
                    w_stateNext = HOLD;
                end else if (i_ireq_addr_ok) begin
                    w_stateNext = WAIT;
                end
            end
            WAIT: begin
                if (i_exc_valid) begin
                    w_discardInc = ~(i_iresp_data_ok & ~w_stale);
                    w_stateNext  = REQ;
                end else if (i_iresp_data_ok & ~w_stale) begin
                    w_latch     = 1'b1;
                    w_stateNext = HOLD;
                end
            end
            HOLD: begin
                if (i_exc_valid) begin
                    w_stateNext = REQ;
                end else if (~i_stallF) begin
                    w_advance   = 1'b1;
                    w_stateNext = REQ;
                end
            end
            default: w_stateNext = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= REQ;
            r_pc         <= RESET_PC;
            r_pendValid  <= 1'b0;
            r_pendPc     <= '0;
            r_discardCnt <= 2'd0;
            r_dataValid  <= 1'b0;
            r_data       <= '0;
        end else begin
            r_state      <= w_stateNext;
            r_discardCnt <= r_discardCnt - {1'b0, w_stale} + {1'b0, w_discardInc};
            if (i_exc_valid || w_advance) begin
                r_pc        <= w_nextPc;
                r_pendValid <= 1'b0;
            end else begin
                r_pendValid <= w_pendValid;
                r_pendPc    <= w_pendPc;
            end
            if (w_latch || w_errLatch) begin
                r_dataValid <= 1'b1;
                r_data      <= '{pc: r_pc, pcplus4: pcPlus4(r_pc),
                                 raw_instr: (w_errLatch ? '0 : i_iresp_data),
                                 exception_instr: w_errLatch};
            end else if (i_exc_valid || w_advance || (i_flushD && !i_stallF)) begin
                r_dataValid <= 1'b0;
            end
        end
    end

    assign o_ireq_valid            = w_ireqValid & resetn;
    assign o_fetch_busy            = (r_state != HOLD) | (r_discardCnt != 2'd0);
    assign o_dataF_valid           = r_dataValid;
    assign o_dataF_pc              = r_data.pc;
    assign o_dataF_pcplus4         = r_data.pcplus4;
    assign o_dataF_raw_instr       = r_data.raw_instr;
    assign o_dataF_exception_instr = EXC_BITS'(r_data.exception_instr);

    // More than three abandoned requests in flight means the bus broke its ordering promise.
    assert property (@(posedge clk) disable iff (!resetn)
        !(w_discardInc && !w_stale && r_discardCnt == 2'd3));
endmodule
